rr_arbiter_16: RTL and testbench
================================

# rr_arbiter_16

Round-robin arbiter sharing one resource among 16 requesters. Requests are encoded by priority, with the lowest index winning inside a rotating mask. Each grant is held until its requester releases it. An optional hold timeout revokes a grant that is held too long. It sits in front of any shared datapath unit and drives that unit's select and valid from `gnt_id`/`gnt_valid`.

## Interface
- `MAX_HOLD`, 15: maximum grant cycles before forced revocation (only with `ARB_TIMEOUT_EN`); legal range 2..255.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  16  request vector; bit i high means requester i wants the resource.
- `gnt`  out  16  one-hot grant, registered; all zero when idle.
- `gnt_id`  out  4  binary index of current grantee; valid only when `gnt_valid`.
- `gnt_valid`  out  1  high when `gnt` is nonzero.
- `timeout`  out  1  one-cycle pulse when a grant is forcibly revoked; constant 0 without `ARB_TIMEOUT_EN`.

## Operation
- State machine has two states:
  - IDLE: no grant.
  - GRANT: `gnt[gnt_id]` held.
- Last-grant pointer `last` (4 bits) is updated to the winner index on every new grant.
- Winner selection:
  - `masked = req & mask`, where `mask` has bits `last+1..15` set; `last=15` gives an all-zero mask.
  - If `masked != 0`, the winner is the lowest set bit of `masked`; otherwise it is the lowest set bit of `req`.
- IDLE:
  - If `req != 0`, go to GRANT with the winner.
  - Otherwise stay in IDLE.
- GRANT, release (`req[gnt_id]==0`):
  - Use candidate set `req & ~(1<<gnt_id)`.
  - If nonzero, switch directly to that set's winner (rotation from `gnt_id`) and stay in GRANT.
  - Otherwise go to IDLE.
- GRANT, held (`req[gnt_id]==1`): grant is unchanged, unless a timeout fires (see Configuration).
- Requests are level-sensitive and not latched. A request deasserted before it is granted is lost.
- `gnt`, `gnt_id`, `gnt_valid` and `timeout` are all registered outputs.

## Timing
- Reset values: state IDLE, `gnt=0`, `gnt_id=0`, `gnt_valid=0`, `timeout=0`, `last=15`, hold counter 0. After reset, index 0 has highest priority.
- Reset wins over every other event in the same cycle, including mid-grant. Outputs clear on the next edge.
- Request-to-grant latency: `req` sampled high at edge t in IDLE → `gnt` high after edge t (visible in cycle t+1).
- Release-to-next-grant latency: `req[gnt_id]` sampled low at edge t → after edge t, `gnt` shows either the next winner or zero. There is no dead cycle between back-to-back grants.
- A grantee that drops and re-raises `req` in consecutive cycles loses its turn if any other request is pending.
- `gnt` is never multi-hot. `gnt_valid` equals `|gnt` in every cycle.

## Configuration
- Macro: `ARB_TIMEOUT_EN`.
- Defined: an 8-bit hold counter is active.
  - It clears on every new grant and increments each GRANT cycle, saturating at `MAX_HOLD-1`.
  - A timeout fires when the counter equals `MAX_HOLD-1`, `req[gnt_id]` is still high, and another request is pending.
  - On timeout, the grant moves to the rotation winner excluding `gnt_id`, and `timeout` pulses high for one cycle.
  - If no other request is pending, the grant is kept and no pulse is produced.
  - If release and timeout coincide, the event is a normal release with `timeout=0`.
- Undefined: no counter is built, grants are held indefinitely, and `timeout` is tied to 0.

## Structure
- Shared package `arb_pkg`:
  - constants `ARB_N=16` and `ARB_IDW=4`;
  - state encoding `ARB_IDLE=1'b0`, `ARB_GRANT=1'b1`.
- One sub-module, `lowest_one_16`: combinational 16-bit first-set-bit finder producing a one-hot output, a 4-bit index and an any-set flag.
  - Instantiated twice: once on the masked vector, once on the unmasked vector.

## Test plan
- Reset, then `req=16'h0081` held: `gnt=16'h0001` and `gnt_id=0` in the first cycle after the request. Drop `req[0]` → next cycle `gnt=16'h0080`, `gnt_id=7`.
- Rotation: `req=16'hFFFF`, each grantee drops its request for one cycle after being granted → grant order 0,1,2,…,15,0 with no idle gaps.
- Wrap: `last=14`, `req=16'h8002` → `gnt=16'h8000`. After release, `gnt=16'h0002`.
- Reset asserted while `gnt=16'h0010` → next cycle all outputs are 0. With `req=16'h0030` after reset, `gnt=16'h0010` (pointer reset to 15).
- `ARB_TIMEOUT_EN`, `MAX_HOLD=4`, `req=16'h0003` held → `gnt=16'h0001` for 4 cycles, then `gnt=16'h0002` with a one-cycle `timeout` pulse. With `req=16'h0001` alone, no timeout occurs.
- Without `ARB_TIMEOUT_EN`, same stimulus → `gnt=16'h0001` held indefinitely and `timeout` stays 0.

Source files
------------

// File: rtl/arb_pkg.sv
// arb_pkg: shared constants and state encoding for the 16-way round-robin arbiter.
package arb_pkg;
  localparam int ARB_N = 16;
  localparam int ARB_IDW = 4;
  typedef enum logic {ARB_IDLE = 1'b0, ARB_GRANT = 1'b1} arb_state_e;
endpackage

// File: rtl/lowest_one_16.sv
// lowest_one_16: finds the lowest set bit of a 16-bit vector as one-hot, index and any-set flag.
module lowest_one_16 import arb_pkg::*; (
  input  logic [ARB_N-1:0]   vec_i,
  output logic [ARB_N-1:0]   onehot_o,
  output logic [ARB_IDW-1:0] idx_o,
  output logic               any_o
);
  assign onehot_o = vec_i & (~vec_i + 16'd1);
  assign any_o = |vec_i;
  always_comb begin
    idx_o = '0;
    for (int i = ARB_N - 1; i >= 0; i--) if (vec_i[i]) idx_o = ARB_IDW'(i);
  end
endmodule

// File: rtl/rr_arbiter_16.sv
// rr_arbiter_16: 16-requester round-robin arbiter with grant held until release.
// Define ARB_TIMEOUT_EN to revoke grants held for MAX_HOLD cycles while others wait.
module rr_arbiter_16 import arb_pkg::*; #(
  parameter int unsigned MAX_HOLD = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ARB_N-1:0]   req,
  output logic [ARB_N-1:0]   gnt,
  output logic [ARB_IDW-1:0] gnt_id,
  output logic               gnt_valid,
  output logic               timeout
);
  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_hold
    $error("MAX_HOLD must be in 2..255");
  end
  arb_state_e state_q, state_d;
  logic [ARB_N-1:0] gnt_q, gnt_d, cand, mask, m_oh, u_oh, win_oh;
  logic [ARB_IDW-1:0] id_q, id_d, last_q, last_d, m_id, u_id, win_id;
  logic m_any, u_any, held, take, fire;
  always_comb begin
    cand = (state_q == ARB_GRANT) ? req & ~gnt_q : req;
    mask = 16'hFFFF << ({1'b0, last_q} + 5'd1);
    held = (state_q == ARB_GRANT) && |(req & gnt_q);
    take = (!held && u_any) || fire;
    win_oh = m_any ? m_oh : u_oh;
    win_id = m_any ? m_id : u_id;
    state_d = (take || held) ? ARB_GRANT : ARB_IDLE;
    gnt_d = take ? win_oh : held ? gnt_q : '0;
    id_d = take ? win_id : id_q;
    last_d = take ? win_id : last_q;
  end
  lowest_one_16 u_masked (.vec_i(cand & mask), .onehot_o(m_oh), .idx_o(m_id), .any_o(m_any));
  lowest_one_16 u_all    (.vec_i(cand),        .onehot_o(u_oh), .idx_o(u_id), .any_o(u_any));
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      gnt_q <= '0;
      id_q <= '0;
      last_q <= 4'd15;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      id_q <= id_d;
      last_q <= last_d;
    end
  end
`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] LIM = 8'(MAX_HOLD - 1);
  logic [7:0] cnt_q, cnt_d;
  logic timeout_q;
  // cand excludes the grantee while in GRANT, so u_any means someone else is waiting
  assign fire = held && cnt_q == LIM && u_any;
  assign cnt_d = (take || !held) ? '0 : (cnt_q == LIM) ? cnt_q : cnt_q + 8'd1;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      timeout_q <= fire;
    end
  end
  assign timeout = timeout_q;
`else
  assign fire = 1'b0;
  assign timeout = 1'b0;
`endif
  assign gnt = gnt_q;
  assign gnt_id = id_q;
  assign gnt_valid = state_q == ARB_GRANT;
endmodule

// File: tb/tb_rr_arbiter_16.sv
// tb_rr_arbiter_16: scoreboard bench comparing the arbiter against a rotation-search reference model.
module tb_rr_arbiter_16;
  localparam int MH = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic [15:0] req = '0, gnt;
  logic [3:0] gnt_id;
  logic gnt_valid, timeout;
  typedef struct {logic [15:0] g; logic [3:0] id; logic v; logic t;} exp_t;
  exp_t sb[$];
  int n_cmp = 0, n_bad = 0;
  int cur = -1, last = 15, age = 0;

  rr_arbiter_16 #(.MAX_HOLD(MH)) dut (.clk(clk), .rst(rst), .req(req), .gnt(gnt),
    .gnt_id(gnt_id), .gnt_valid(gnt_valid), .timeout(timeout));

  always #5 clk = ~clk;

  function automatic int win(input logic [15:0] c, input int l);
    for (int k = 1; k <= 16; k++) begin
      int j;
      j = (l + k) % 16;
      if (c[j]) return j;
    end
    return -1;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r_rst, input logic [15:0] r);
    exp_t e;
    logic [15:0] others;
    bit t;
    @(negedge clk);
    rst = r_rst;
    req = r;
    t = 1'b0;
    if (r_rst) begin
      cur = -1; last = 15; age = 0;
    end else if (cur < 0) begin
      if (r != 0) begin cur = win(r, last); last = cur; age = 1; end
    end else begin
      others = r & ~(16'h1 << cur);
      if (!r[cur]) begin
        if (others != 0) begin cur = win(others, last); last = cur; age = 1; end
        else begin cur = -1; age = 0; end
      end else begin
`ifdef ARB_TIMEOUT_EN
        if (age >= MH && others != 0) begin
          cur = win(others, last); last = cur; age = 1; t = 1'b1;
        end else age++;
`else
        age++;
`endif
      end
    end
    e.g = (cur < 0) ? 16'h0 : 16'h1 << cur;
    e.id = (cur < 0) ? 4'd0 : 4'(cur);
    e.v = cur >= 0;
    e.t = t;
    sb.push_back(e);
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("gnt", gnt, e.g);
      chk("gnt_valid", 16'(gnt_valid), 16'(e.v));
      chk("timeout", 16'(timeout), 16'(e.t));
      if (e.v) chk("gnt_id", 16'(gnt_id), 16'(e.id));
      chk("onehot", 16'($countones(gnt) <= 1), 16'h1);
      chk("valid_eq_or", 16'(gnt_valid), 16'(|gnt));
    end
  end

  initial begin
    logic [15:0] r;
    step(1'b1, 16'h0);
    step(1'b1, 16'h0);
    repeat (3) step(1'b0, 16'h0081);
    repeat (2) step(1'b0, 16'h0080);
    step(1'b0, 16'h0);
    step(1'b0, 16'hFFFF);
    for (int i = 0; i < 18; i++) step(1'b0, ~(16'h1 << cur));
    step(1'b0, 16'h0);
    step(1'b0, 16'h4000);
    repeat (2) step(1'b0, 16'h8002);
    repeat (2) step(1'b0, 16'h0002);
    repeat (2) step(1'b0, 16'h0010);
    step(1'b1, 16'h0010);
    repeat (2) step(1'b0, 16'h0030);
    step(1'b1, 16'h0);
    repeat (12) step(1'b0, 16'h0003);
    step(1'b0, 16'h0);
    repeat (10) step(1'b0, 16'h0001);
    r = '0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(7) == 0) r = 16'($urandom);
      else if (cur >= 0 && $urandom_range(2) == 0) r[cur] = 1'b0;
      else if ($urandom_range(3) == 0) r[$urandom_range(15)] = 1'b1;
      step($urandom_range(199) == 0, r);
    end
    @(posedge clk);
    #2;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
